// File: rtl/nios_practica_sample_in.sv
// nios_practica_sample_in
//
// Avalon-MM slave input port. External logic strobes samples into a small
// FIFO. The CPU drains the FIFO, reads status and takes an interrupt through
// a four-word register map. Zero wait states; readdata is combinational
// from address.
//
// Register map (word addresses, unused bits read 0):
//   0 DATA    : read = zero-extended head sample, pops when not empty
//   1 STATUS  : [0] empty, [1] full, [2] overflow (sticky, write 1 clears),
//               [8 +: DEPTH_LOG2+1] count
//   2 IRQMASK : [0] level irq enable, [1] overflow irq enable
//   3 CONTROL : [3:0] threshold; write [31]=1 flushes the FIFO (reads 0)
//
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   address    : register word select
//   chipselect : slave select
//   read_n     : active-low read strobe
//   write_n    : active-low write strobe
//   writedata  : CPU write data
//   in_port    : sample data, synchronous to clk
//   in_valid   : push strobe, one sample per high cycle
//   readdata   : CPU read data
//   irq        : registered interrupt request, active high
module nios_practica_sample_in #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  input  logic                  in_valid,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  // Sample storage. Contents need no reset: count gates every read.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] head_reg;
  logic [DEPTH_LOG2-1:0] tail_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg;
  logic [1:0]            mask_reg;
  logic [3:0]            threshold_reg;
  logic                  irq_reg;

  logic [CW-1:0]         count_next;
  logic                  overflow_next;
  logic                  irq_next;

  logic rd;
  logic wr;
  logic empty;
  logic full;
  logic pop;
  logic push;
  logic flush;
  logic overflow_set;
  logic overflow_clr;

  // ---------------------------------------------------------------------
  // Bus strobes and FIFO control
  // ---------------------------------------------------------------------
  assign rd = chipselect & ~read_n;
  assign wr = chipselect & ~write_n;

  assign empty = (count_reg == CW'(0));
  assign full  = (count_reg == CW'(DEPTH));

  assign flush = wr & (address == ADDR_CONTROL) & writedata[31];

  // A DATA read on an empty FIFO is harmless: it reads 0 and pops nothing.
  // Flush dominates every FIFO movement in the same cycle.
  assign pop  = rd & (address == ADDR_DATA) & ~empty & ~flush;

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle, so the slot frees up just in time.
  assign push = in_valid & (~full | pop) & ~flush;

  // A sample is lost only when full with no pop; a flush drops the sample
  // silently without flagging overflow.
  assign overflow_set = in_valid & full & ~pop & ~flush;
  assign overflow_clr = wr & (address == ADDR_STATUS) & writedata[2];

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Set beats clear so a drop in the clearing cycle is never lost.
  always_comb begin
    overflow_next = overflow_reg;
    if (overflow_set) begin
      overflow_next = 1'b1;
    end else if (overflow_clr) begin
      overflow_next = 1'b0;
    end
  end

  // Level term looks at the count after this edge so irq tracks the FIFO
  // with exactly one register of latency. Threshold 0 disables the level
  // term; thresholds above the depth can never be reached.
  always_comb begin
    irq_next = 1'b0;
    if (mask_reg[0] && (threshold_reg != 4'd0) &&
        (32'(count_next) >= 32'(threshold_reg))) begin
      irq_next = 1'b1;
    end
    if (mask_reg[1] && overflow_next) begin
      irq_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Storage write port
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= in_port;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      mask_reg      <= 2'b00;
      threshold_reg <= 4'd1;
      irq_reg       <= 1'b0;
    end else begin
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      irq_reg      <= irq_next;

      // Pointers wrap naturally at the power-of-two depth.
      if (flush) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        if (pop) begin
          head_reg <= head_reg + DEPTH_LOG2'(1);
        end
        if (push) begin
          tail_reg <= tail_reg + DEPTH_LOG2'(1);
        end
      end

      if (wr && (address == ADDR_IRQMASK)) begin
        mask_reg <= writedata[1:0];
      end
      if (wr && (address == ADDR_CONTROL)) begin
        threshold_reg <= writedata[3:0];
      end
    end
  end

  assign irq = irq_reg;

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: begin
        if (!empty) begin
          readdata[DATA_WIDTH-1:0] = mem[head_reg];
        end
      end
      ADDR_STATUS: begin
        readdata[0]       = empty;
        readdata[1]       = full;
        readdata[2]       = overflow_reg;
        readdata[8 +: CW] = count_reg;
      end
      ADDR_IRQMASK: begin
        readdata[1:0] = mask_reg;
      end
      default: begin
        readdata[3:0] = threshold_reg;
      end
    endcase
  end

endmodule

// File: tb/tb_nios_practica_sample_in.sv
// Directed bench for nios_practica_sample_in. Inputs change just after a
// rising edge or on the falling edge; outputs are sampled mid-cycle.
module tb_nios_practica_sample_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [15:0] in_port = '0;
  logic        in_valid = 1'b0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_practica_sample_in #(.DATA_WIDTH(16), .DEPTH_LOG2(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .in_valid   (in_valid),
    .readdata   (readdata),
    .irq        (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
    $display("check %-12s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // One read cycle: readdata sampled mid-cycle, access completes at the edge.
  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 check(tag, readdata, exp);
    @(posedge clk);
    #1 chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk);
    #1 chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    in_port = d; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    $display("push 0x%04h", d);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1 check("rst_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd1, 32'h0000_0001, "rst_status");
    bus_read(2'd3, 32'h0000_0001, "rst_thresh");
    bus_read(2'd0, 32'h0000_0000, "rst_data");
    bus_read(2'd2, 32'h0000_0000, "rst_mask");

    // Two samples in, two out
    push(16'h1234);
    push(16'hABCD);
    bus_read(2'd1, 32'h0000_0200, "two_status");
    bus_read(2'd0, 32'h0000_1234, "two_data0");
    bus_read(2'd0, 32'h0000_ABCD, "two_data1");
    bus_read(2'd1, 32'h0000_0001, "two_empty");

    // Overfill by one
    for (int i = 1; i <= 9; i++) push(16'(i));
    bus_read(2'd1, 32'h0000_0806, "ovf_status");
    for (int i = 1; i <= 8; i++) bus_read(2'd0, 32'(i), "ovf_data");
    bus_write(2'd1, 32'h0000_0004);
    bus_read(2'd1, 32'h0000_0001, "ovf_cleared");

    // Full FIFO, push in the same cycle as a pop
    for (int i = 0; i < 8; i++) push(16'h0010 + 16'(i));
    bus_read(2'd1, 32'h0000_0802, "full_status");
    @(negedge clk);
    address = 2'd0; chipselect = 1'b1; read_n = 1'b0;
    in_port = 16'h00EE; in_valid = 1'b1;
    #1 check("pp_head", readdata, 32'h0000_0010);
    @(posedge clk);
    #1 chipselect = 1'b0; read_n = 1'b1; in_valid = 1'b0;
    bus_read(2'd1, 32'h0000_0802, "pp_status");
    for (int i = 1; i < 8; i++) bus_read(2'd0, 32'h0000_0010 + 32'(i), "pp_data");
    bus_read(2'd0, 32'h0000_00EE, "pp_last");
    bus_read(2'd1, 32'h0000_0001, "pp_empty");

    // Level interrupt
    bus_write(2'd3, 32'h0000_0003);
    bus_write(2'd2, 32'h0000_0001);
    push(16'h0A01);
    check("irq_p1", {31'd0, irq}, 32'd0);
    push(16'h0A02);
    check("irq_p2", {31'd0, irq}, 32'd0);
    push(16'h0A03);
    check("irq_p3", {31'd0, irq}, 32'd1);
    bus_read(2'd0, 32'h0000_0A01, "irq_pop");
    check("irq_fall", {31'd0, irq}, 32'd0);
    bus_read(2'd1, 32'h0000_0200, "irq_status");
    bus_write(2'd3, 32'h8000_0003);
    check("flush_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd1, 32'h0000_0001, "flush_status");
    bus_read(2'd3, 32'h0000_0003, "flush_thresh");

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) push(16'h0B00 + 16'(i));
    bus_read(2'd1, 32'h0000_0500, "mid_status");
    @(negedge clk);
    address = 2'd1; reset_n = 1'b0;
    #1 check("mrst_status", readdata, 32'h0000_0001);
    check("mrst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    bus_read(2'd2, 32'h0000_0000, "mrst_mask");
    bus_read(2'd3, 32'h0000_0001, "mrst_thresh");
    push(16'h5A5A);
    bus_read(2'd0, 32'h0000_5A5A, "mrst_data");
    bus_read(2'd1, 32'h0000_0001, "mrst_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
